// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the counter library: the two-state timer FSM
// encoding, the largest legal BCD digit and a BCD nibble validity check.
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_valid_bcd(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit
// One BCD digit of a down counter.
// Ports:
//   clk, reset  : clock and synchronous active-high reset (value -> 0)
//   load        : take load_d this cycle (has priority over dec)
//   load_d      : 4-bit BCD value to load
//   dec         : decrement this cycle; 0 wraps to 9
//   value       : current digit
//   is_zero     : value == 0
//   borrow_out  : dec while at zero, i.e. the next digit up must decrement
module bcd_down_digit
    import counter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_d,
    input  logic       dec,
    output logic [3:0] value,
    output logic       is_zero,
    output logic       borrow_out
);

    logic [3:0] value_reg;

    assign value      = value_reg;
    assign is_zero    = (value_reg == 4'd0);
    assign borrow_out = dec & is_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg <= 4'd0;
        end else if (load) begin
            value_reg <= load_d;
        end else if (dec) begin
            value_reg <= is_zero ? BCD_MAX : (value_reg - 4'd1);
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// bcd_down_timer
// Multi-digit BCD countdown timer with a valid/ready preset load, start/stop
// control, one decrement per tick, a one-cycle done pulse on expiry and an
// optional auto-reload for periodic operation.
// Parameters:
//   DIGITS      : number of BCD digits (1..8)
//   AUTO_RELOAD : 1 = reload the preset on expiry and keep running
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   load_valid  : preset offered on load_value (digit 0 in bits [3:0])
//   load_ready  : high exactly while IDLE
//   start, stop : begin / halt counting (stop wins when both are high)
//   tick        : count enable
//   count       : current BCD value
//   running     : high while RUN
//   done        : one-cycle expiry pulse
//   load_err    : one-cycle pulse after a preset with a nibble above 9
module bcd_down_timer
    import counter_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                start,
    input  logic                stop,
    input  logic                tick,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                done,
    output logic                load_err
);

    localparam int   W         = 4 * DIGITS;
    localparam logic RELOAD_EN = (AUTO_RELOAD != 0);

    timer_state_t     state_reg, state_next;
    logic [W-1:0]     reload_reg;
    logic             done_reg, load_err_reg, running_reg, load_ready_reg;

    logic [DIGITS-1:0] nib_ok, is_zero, dec, borrow;
    logic [W-1:0]      count_w;

    logic         load_fire, preset_ok, count_zero, count_one;
    logic         step, expire, go, restart, dec_en, digit_load;
    logic [W-1:0] digit_load_d;

    // Per-digit validation and the digit chain. Digit 0 decrements on an
    // accepted step; every higher digit decrements on the borrow of the
    // digit below, so the whole ripple settles in one cycle.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib_ok[gi] = is_valid_bcd(load_value[4*gi +: 4]);

            if (gi == 0) begin : g_lsd
                assign dec[gi] = dec_en;
            end else begin : g_upper
                assign dec[gi] = borrow[gi-1];
            end

            bcd_down_digit u_digit (
                .clk        (clk),
                .reset      (reset),
                .load       (digit_load),
                .load_d     (digit_load_d[4*gi +: 4]),
                .dec        (dec[gi]),
                .value      (count_w[4*gi +: 4]),
                .is_zero    (is_zero[gi]),
                .borrow_out (borrow[gi])
            );
        end
    endgenerate

    always_comb begin
        load_fire    = load_valid && (state_reg == IDLE);
        preset_ok    = &nib_ok;
        count_zero   = &is_zero;
        count_one    = (count_w == W'(1));

        // A tick only counts in RUN when stop is not also asserted.
        step         = (state_reg == RUN) && tick && !stop && !count_zero;
        expire       = step && count_one;

        // A start in the same cycle as a load handshake is ignored so the
        // count source for that cycle is unambiguous.
        go           = (state_reg == IDLE) && start && !stop && !load_fire &&
                       !(count_zero && (reload_reg == '0));
        restart      = go && count_zero;

        digit_load   = (load_fire && preset_ok) || restart || (expire && RELOAD_EN);
        digit_load_d = load_fire ? load_value : reload_reg;

        // On an auto-reload expiry the load replaces the 1 -> 0 decrement,
        // so count never shows 0 and the period is exactly N ticks.
        dec_en       = step && !(expire && RELOAD_EN);

        state_next   = state_reg;
        case (state_reg)
            IDLE: if (go) state_next = RUN;
            RUN: begin
                // A borrow out of the top digit would mean a decrement from
                // zero; dec_en excludes that, this is only a backstop.
                if (stop || (expire && !RELOAD_EN) || borrow[DIGITS-1])
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            reload_reg     <= '0;
            done_reg       <= 1'b0;
            load_err_reg   <= 1'b0;
            running_reg    <= 1'b0;
            load_ready_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            done_reg       <= expire;
            load_err_reg   <= load_fire && !preset_ok;
            running_reg    <= (state_next == RUN);
            load_ready_reg <= (state_next == IDLE);
            if (load_fire && preset_ok)
                reload_reg <= load_value;
        end
    end

    assign count      = count_w;
    assign running    = running_reg;
    assign done       = done_reg;
    assign load_err   = load_err_reg;
    assign load_ready = load_ready_reg;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Testbench for bcd_down_timer. Two instances share one stimulus stream:
// dut0 stops at zero, dut1 auto-reloads. A decimal-integer model of each is
// compared with the DUTs on every falling edge; directed literal checks pin
// the test-plan values.
module tb_bcd_down_timer;

    logic        clk = 1'b0;
    logic        reset, load_valid, start, stop, tick;
    logic [15:0] load_value;

    logic [15:0] count0, count1;
    logic        running0, done0, load_err0, load_ready0;
    logic        running1, done1, load_err1, load_ready1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_down_timer #(.DIGITS(4), .AUTO_RELOAD(0)) dut0 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready0),
        .load_value(load_value), .start(start), .stop(stop), .tick(tick),
        .count(count0), .running(running0), .done(done0), .load_err(load_err0)
    );

    bcd_down_timer #(.DIGITS(4), .AUTO_RELOAD(1)) dut1 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready1),
        .load_value(load_value), .start(start), .stop(stop), .tick(tick),
        .count(count1), .running(running1), .done(done1), .load_err(load_err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        int v;
        v = 0;
        for (int k = 3; k >= 0; k--) v = v * 10 + int'(b[4*k +: 4]);
        return v;
    endfunction

    function automatic bit bcd_ok(input logic [15:0] b);
        for (int k = 0; k < 4; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Behavioural model: the count is a plain decimal integer.
    int m_val [2];
    int m_rel [2];
    bit m_run [2];
    bit m_done[2];
    bit m_err [2];
    bit model_started = 1'b0;

    always @(posedge clk) begin
        model_started <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            automatic int v  = m_val[i];
            automatic int r  = m_rel[i];
            automatic bit rn = m_run[i];
            automatic bit dn = 1'b0;
            automatic bit er = 1'b0;
            if (reset) begin
                v = 0; r = 0; rn = 1'b0;
            end else if (!rn) begin
                if (load_valid) begin
                    if (bcd_ok(load_value)) begin
                        v = from_bcd(load_value);
                        r = v;
                    end else begin
                        er = 1'b1;
                    end
                end else if (start && !stop) begin
                    if (v != 0) rn = 1'b1;
                    else if (r != 0) begin v = r; rn = 1'b1; end
                end
            end else begin
                if (stop) rn = 1'b0;
                else if (tick && v > 0) begin
                    if (v == 1) begin
                        dn = 1'b1;
                        if (i == 1) v = r;
                        else begin v = 0; rn = 1'b0; end
                    end else begin
                        v = v - 1;
                    end
                end
            end
            m_val[i]  <= v;
            m_rel[i]  <= r;
            m_run[i]  <= rn;
            m_done[i] <= dn;
            m_err[i]  <= er;
        end
    end

    always @(negedge clk) begin
        if (model_started) begin
            chk("m0_count",   count0,      to_bcd(m_val[0]));
            chk("m0_running", running0,    m_run[0]);
            chk("m0_ready",   load_ready0, !m_run[0]);
            chk("m0_done",    done0,       m_done[0]);
            chk("m0_err",     load_err0,   m_err[0]);
            chk("m1_count",   count1,      to_bcd(m_val[1]));
            chk("m1_running", running1,    m_run[1]);
            chk("m1_ready",   load_ready1, !m_run[1]);
            chk("m1_done",    done1,       m_done[1]);
            chk("m1_err",     load_err1,   m_err[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load_valid = 1'b1;
        load_value = v;
        step();
        load_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    logic [15:0] seq12 [12] = '{16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                                16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
    logic [15:0] seq3  [9]  = '{16'h0002, 16'h0001, 16'h0003, 16'h0002, 16'h0001,
                                16'h0003, 16'h0002, 16'h0001, 16'h0003};

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_value = 16'h0000;
        start = 1'b0; stop = 1'b0; tick = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_count", count0, 16'h0000);
        chk("rst_ready", load_ready0, 1'b1);
        chk("rst_running", running0, 1'b0);
        chk("rst_done", done0, 1'b0);

        // Count 12 down to zero.
        do_load(16'h0012);
        $display("load 0x0012 -> count0=%h", count0);
        chk("load12", count0, 16'h0012);
        do_start();
        chk("start12_running", running0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick = 1'b1;
            step();
            $display("tick %0d -> count0=%h done0=%b", i + 1, count0, done0);
            chk("seq12_count", count0, seq12[i]);
            chk("seq12_done", done0, (i == 11));
        end
        tick = 1'b0;
        chk("seq12_idle", running0, 1'b0);
        do_stop();

        // Multi-digit borrow.
        do_load(16'h0100);
        do_start();
        tick = 1'b1; step(); tick = 1'b0;
        $display("0x0100 tick -> count0=%h", count0);
        chk("borrow_count", count0, 16'h0099);
        chk("borrow_done", done0, 1'b0);
        do_stop();

        // Auto-reload on dut1.
        do_load(16'h0003);
        do_start();
        for (int i = 0; i < 9; i++) begin
            tick = 1'b1;
            step();
            $display("ar tick %0d -> count1=%h done1=%b", i + 1, count1, done1);
            chk("ar_count", count1, seq3[i]);
            chk("ar_done", done1, (i % 3 == 2));
            chk("ar_running", running1, 1'b1);
        end
        tick = 1'b0;
        do_stop();

        // Rejected preset.
        do_load(16'h00A5);
        $display("load 0x00A5 -> err0=%b count0=%h", load_err0, count0);
        chk("err_pulse", load_err0, 1'b1);
        chk("err_count0", count0, 16'h0000);
        chk("err_count1", count1, 16'h0003);
        step();
        chk("err_clear", load_err0, 1'b0);

        // Load offered during RUN.
        do_load(16'h0007);
        do_start();
        do_load(16'h0042);
        $display("load in RUN -> ready0=%b count0=%h", load_ready0, count0);
        chk("run_ready", load_ready0, 1'b0);
        chk("run_count", count0, 16'h0007);
        do_stop();

        // stop beats tick, then resume.
        do_load(16'h0005);
        do_start();
        stop = 1'b1; tick = 1'b1; step(); stop = 1'b0; tick = 1'b0;
        $display("stop+tick -> count0=%h running0=%b", count0, running0);
        chk("stoptick_count", count0, 16'h0005);
        chk("stoptick_idle", running0, 1'b0);
        do_start();
        chk("resume_running", running0, 1'b1);
        tick = 1'b1; step(); tick = 1'b0;
        chk("resume_count", count0, 16'h0004);
        do_stop();

        // Reset mid-RUN, then start with reload cleared.
        do_load(16'h0002);
        do_start();
        reset = 1'b1; step(); reset = 1'b0;
        $display("reset in RUN -> count0=%h running0=%b done0=%b", count0, running0, done0);
        chk("rstrun_count", count0, 16'h0000);
        chk("rstrun_idle", running0, 1'b0);
        chk("rstrun_done", done0, 1'b0);
        do_start();
        chk("start_zero_idle", running0, 1'b0);
        chk("start_zero_idle1", running1, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Multi-digit BCD countdown timer: the down-counting counterpart of the decade (mod-10) up counter in the counters library. It loads a BCD preset through a valid/ready handshake. It decrements one count per enabled `tick`, with borrow rippling 0→9 across digits, and pulses `done` on expiry. It can optionally auto-reload for periodic operation. It sits beside the up counters and is driven by a prescaler tick.

## Interface
- `DIGITS`, default 4: number of BCD digits (1–8).
- `AUTO_RELOAD`, default 0: 1 = reload the preset on expiry and keep running; 0 = stop at zero.

- `clk`  in  1: single clock; everything is on the rising edge.
- `reset`  in  1: synchronous reset, active-high.
- `load_valid`  in  1: a preset is offered on `load_value`.
- `load_ready`  out  1: a preset can be accepted; equals 1 exactly when the state is IDLE.
- `load_value`  in  4*DIGITS: BCD preset; digit 0 is in bits [3:0].
- `start`  in  1: begin counting.
- `stop`  in  1: halt counting and hold the current count.
- `tick`  in  1: count enable, one decrement per cycle in which it is high.
- `count`  out  4*DIGITS: current BCD value.
- `running`  out  1: high in state RUN.
- `done`  out  1: one-cycle expiry pulse.
- `load_err`  out  1: one-cycle pulse when a preset is rejected.

## Operation
- Reset values:
  - `count`=0, reload register=0, state=IDLE.
  - `running`=0, `done`=0, `load_err`=0, `load_ready`=1.
  - Reset mid-RUN aborts immediately, with no `done` pulse.
- States: IDLE, RUN.
- Load, accepted when `load_valid & load_ready` in IDLE:
  - If every nibble ≤ 9: `count` and the reload register take `load_value`.
  - If any nibble > 9: pulse `load_err`; `count` and the reload register are unchanged.
- Load in RUN: `load_ready`=0, nothing is accepted, and `load_valid` has no effect.
- IDLE→RUN on `start`:
  - If `count`≠0: count down from the current value.
  - If `count`=0 and reload≠0: `count`←reload (restart).
  - If `count`=0 and reload=0: `start` is ignored.
- RUN→IDLE on `stop`; `count` is held.
- Simultaneous events:
  - `stop` has priority over `tick`: no decrement that cycle.
  - `start & stop` in IDLE: stop wins, the state stays IDLE.
- RUN with `tick`, `count`>1: BCD decrement. Digit k decrements when all lower digits are 0; a digit at 0 that decrements wraps to 9.
- RUN with `tick`, `count`==1 (expiry):
  - `AUTO_RELOAD`=0: `count`←0, `done`=1, state→IDLE.
  - `AUTO_RELOAD`=1: `count`←reload, `done`=1, state stays RUN. `count` never shows 0, so the period is exactly N ticks for preset N.
- `tick` while in IDLE is ignored.
- `count` never holds a non-BCD nibble.

## Timing
- All outputs are registered.
- `count`, `done` and `running` change in the cycle after the inputs are sampled.
- `done` is high for exactly one cycle, coincident with `count` showing 0 (or the reload value).
- Load latency is 1 cycle: `count` shows the new preset in the cycle after the handshake.
- `load_err` is asserted in the cycle after the rejected handshake.
- Ticks on consecutive cycles decrement on consecutive cycles; there is no dead cycle after a wrap or a reload.
- The borrow chain is combinational across all digits and settles within one cycle.

## Structure
- Shared package `counter_pkg`:
  - state enum typedef (IDLE, RUN);
  - constant `BCD_MAX`=4'd9;
  - function `is_valid_bcd(nibble)`.
- Sub-module `bcd_down_digit`, instantiated DIGITS times:
  - 4-bit register with `load`, `load_d` and `dec` inputs;
  - outputs `is_zero` and `borrow_out = dec & is_zero`;
  - on `dec` at zero it wraps to 9.
- The top level holds the FSM, the reload register, preset validation, the expiry compare and the output flops.

## Test plan
- Reset, then load 0x0012 and start, then 12 ticks → `count` 0x0011…0x0001, 0x0000. `done`=1 only on the 12th, `running`=0 afterwards.
- Load 0x0100, start, 1 tick → `count`=0x0099 (multi-digit borrow wrap); `done` stays 0.
- `AUTO_RELOAD`=1, load 0x0003, start, 9 ticks → `count` sequence 2,1,3,2,1,3,2,1,3. `done` pulses on ticks 3, 6 and 9; `running` stays 1.
- Load 0x00A5 → `load_err`=1 for one cycle and `count` is unchanged. Load during RUN → `load_ready`=0 and nothing changes.
- With `count`=0x0005 in RUN: `stop` and `tick` in the same cycle → `count`=0x0005, IDLE. `start` → resumes, and the next tick gives 0x0004.
- At `count`=0x0002 in RUN, assert `reset` → next cycle `count`=0, IDLE, no `done`. `start` with reload=0 → stays IDLE.
